// File: rtl/cmp_sort_pkg.sv
// ============================================================================
// Module   : cmp_sort_pkg
// Purpose  : Shared types and constants for the compare-and-swap sorter:
//            controller state encoding, default sizes and the helper that
//            gives the full bubble-sort comparison total for a block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmp_sort_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 8;

    // Controller phases: fill the buffer, sort in place, stream out.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Comparisons needed for a full bubble sort of n words.
    function automatic int cmp_total(input int n);
        return (n * (n - 1)) / 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_swap_unit.sv
// ============================================================================
// Module   : cmp_swap_unit
// Purpose  : Combinational unsigned magnitude compare-and-swap. Orders the
//            pair (a, b) into (lo, hi); swap flags a strictly greater than b,
//            so equal operands are never exchanged.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_swap_unit #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         swap
);

    // Strict greater-than keeps the sort stable for equal words.
    always_comb begin
        swap = (a > b);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

`default_nettype wire

// File: rtl/cmp_sort_ctrl.sv
// ============================================================================
// Module   : cmp_sort_ctrl
// Purpose  : Loads N unsigned words over valid/ready, bubble-sorts them in
//            place with one shared compare-and-swap unit (one comparison per
//            clock) and streams them out in ascending order.
// Options  : SORT_EARLY_EXIT_EN - when defined, a pass with no swaps ends the
//            sort early; otherwise every block takes N(N-1)/2 comparisons.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_sort_ctrl
    import cmp_sort_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic [7:0]   cmp_count
);

    localparam int              c_IW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_IW-1:0] c_LAST_IDX  = c_IW'(N - 1);
    localparam logic [c_IW-1:0] c_LAST_PASS = c_IW'(N - 2);

    state_t          r_state;
    logic [W-1:0]    r_buf [N];
    logic [c_IW-1:0] r_wr_idx;
    logic [c_IW-1:0] r_rd_idx;
    logic [c_IW-1:0] r_i;
    logic [c_IW-1:0] r_pass;

    logic [c_IW-1:0] w_ip1;
    logic [c_IW-1:0] w_rd_nxt;
    logic [W-1:0]    w_lo;
    logic [W-1:0]    w_hi;
    logic            w_swap;
    logic            w_pass_end;
    logic            w_early;
    logic            w_sort_done;

    assign w_ip1      = r_i + c_IW'(1);
    assign w_rd_nxt   = r_rd_idx + c_IW'(1);
    // Each pass bubbles the largest remaining word to the top, so the pass
    // shrinks by one compare each time.
    assign w_pass_end  = (r_i == (c_LAST_PASS - r_pass));
    assign w_sort_done = w_pass_end && ((r_pass == c_LAST_PASS) || w_early);

    // The single shared comparator, always looking at the adjacent pair at r_i.
    cmp_swap_unit #(
        .W    (W)
    ) u_cmp_swap (
        .a    (r_buf[r_i]),
        .b    (r_buf[w_ip1]),
        .lo   (w_lo),
        .hi   (w_hi),
        .swap (w_swap)
    );

`ifdef SORT_EARLY_EXIT_EN
    logic r_swapped;

    // Remember whether the current pass has exchanged anything so far.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_swapped <= 1'b0;
        end else if (r_state == SORT && !w_pass_end) begin
            r_swapped <= r_swapped | w_swap;
        end else begin
            r_swapped <= 1'b0;
        end
    end

    assign w_early = ~(r_swapped | w_swap);
`else
    assign w_early = 1'b0;
`endif

    // Load / sort / output sequencer with registered handshake and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= LOAD;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmp_count <= 8'd0;
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_i       <= '0;
            r_pass    <= '0;
            for (int k = 0; k < N; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        r_buf[r_wr_idx] <= in_data;
                        if (r_wr_idx == c_LAST_IDX) begin
                            r_state   <= SORT;
                            in_ready  <= 1'b0;
                            busy      <= 1'b1;
                            r_wr_idx  <= '0;
                            r_pass    <= '0;
                            r_i       <= '0;
                            cmp_count <= 8'd0;
                        end else begin
                            r_wr_idx <= r_wr_idx + c_IW'(1);
                        end
                    end
                end

                SORT: begin
                    if (w_swap) begin
                        r_buf[r_i]   <= w_lo;
                        r_buf[w_ip1] <= w_hi;
                    end
                    if (cmp_count != 8'hFF) begin
                        cmp_count <= cmp_count + 8'd1;
                    end
                    if (w_sort_done) begin
                        r_state   <= OUT;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        // Entry 0 may be rewritten on this very edge.
                        out_data  <= (r_i == '0) ? w_lo : r_buf[0];
                        r_rd_idx  <= '0;
                        r_i       <= '0;
                        r_pass    <= '0;
                    end else if (w_pass_end) begin
                        r_pass <= r_pass + c_IW'(1);
                        r_i    <= '0;
                    end else begin
                        r_i <= w_ip1;
                    end
                end

                OUT: begin
                    if (out_ready) begin
                        if (r_rd_idx == c_LAST_IDX) begin
                            done      <= 1'b1;
                            r_state   <= LOAD;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            r_rd_idx  <= '0;
                        end else begin
                            r_rd_idx <= w_rd_nxt;
                            out_data <= r_buf[w_rd_nxt];
                        end
                    end
                end

                default: begin
                    r_state   <= LOAD;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cmp_sort_ctrl.sv
// ============================================================================
// Module   : tb_cmp_sort_ctrl
// Purpose  : Directed self-checking bench for cmp_sort_ctrl (N=4, W=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_sort_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [7:0] cmp_count;

    int         checks;
    int         failures;
    logic [7:0] got [4];
    int         got_done;
    int         sort_cycles;
    int         pass0_swaps;

`ifdef SORT_EARLY_EXIT_EN
    localparam int c_SORTED_CMPS = 3;
`else
    localparam int c_SORTED_CMPS = 6;
`endif

    cmp_sort_ctrl #(
        .N         (4),
        .W         (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .cmp_count (cmp_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present four words back to back; in_ready is high throughout LOAD.
    task automatic load4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        logic [7:0] v [4];
        v = '{a, b, c, d};
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = v[k];
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Count SORT cycles and swaps seen in the first pass; -1 on timeout.
    task automatic wait_sort();
        sort_cycles = 0;
        pass0_swaps = 0;
        while (busy && sort_cycles < 100) begin
            if (sort_cycles < 3 && dut.w_swap) pass0_swaps++;
            tick();
            sort_cycles++;
        end
        if (busy) sort_cycles = -1;
    endtask

    // Accept four words with out_ready high, tallying done pulses seen.
    task automatic drain();
        int bound;
        out_ready = 1'b1;
        got_done  = 0;
        for (int k = 0; k < 4; k++) begin
            bound = 0;
            while (!out_valid && bound < 20) begin
                tick();
                bound++;
            end
            got[k] = out_valid ? out_data : 8'hEE;
            if (done) got_done++;
            tick();
        end
        if (done) got_done++;
        tick();
        if (done) got_done++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (cmp_count !== 8'd0) begin failures++; $display("FAIL reset_cmp_count: got %0d expected 0", cmp_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reverse();
        logic [7:0] exp [4];
        exp = '{8'd1, 8'd2, 8'd3, 8'd4};
        load4(8'd4, 8'd3, 8'd2, 8'd1);
        wait_sort();
        checks++; if (sort_cycles != 6) begin failures++; $display("FAIL reverse_busy_cycles: got %0d expected 6", sort_cycles); end
        checks++; if (cmp_count !== 8'd6) begin failures++; $display("FAIL reverse_cmp_count: got %0d expected 6", cmp_count); end
        drain();
        for (int k = 0; k < 4; k++) begin
            checks++; if (got[k] !== exp[k]) begin failures++; $display("FAIL reverse_word%0d: got %0d expected %0d", k, got[k], exp[k]); end
        end
        checks++; if (got_done != 1) begin failures++; $display("FAIL reverse_done_pulses: got %0d expected 1", got_done); end
        checks++; if (cmp_count !== 8'd6) begin failures++; $display("FAIL reverse_cmp_hold: got %0d expected 6", cmp_count); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL reverse_back_to_load: got in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_sorted();
        logic [7:0] exp [4];
        exp = '{8'd1, 8'd2, 8'd3, 8'd4};
        load4(8'd1, 8'd2, 8'd3, 8'd4);
        wait_sort();
        checks++; if (sort_cycles != c_SORTED_CMPS) begin failures++; $display("FAIL sorted_busy_cycles: got %0d expected %0d", sort_cycles, c_SORTED_CMPS); end
        checks++; if (cmp_count !== 8'(c_SORTED_CMPS)) begin failures++; $display("FAIL sorted_cmp_count: got %0d expected %0d", cmp_count, c_SORTED_CMPS); end
        drain();
        for (int k = 0; k < 4; k++) begin
            checks++; if (got[k] !== exp[k]) begin failures++; $display("FAIL sorted_word%0d: got %0d expected %0d", k, got[k], exp[k]); end
        end
        checks++; if (got_done != 1) begin failures++; $display("FAIL sorted_done_pulses: got %0d expected 1", got_done); end
    endtask

    task automatic test_equal_words();
        logic [7:0] exp [4];
        exp = '{8'h02, 8'h05, 8'h05, 8'hFF};
        load4(8'h05, 8'h05, 8'h02, 8'hFF);
        wait_sort();
        checks++; if (pass0_swaps != 1) begin failures++; $display("FAIL equal_pass0_swaps: got %0d expected 1", pass0_swaps); end
        checks++; if (cmp_count !== 8'd6) begin failures++; $display("FAIL equal_cmp_count: got %0d expected 6", cmp_count); end
        drain();
        for (int k = 0; k < 4; k++) begin
            checks++; if (got[k] !== exp[k]) begin failures++; $display("FAIL equal_word%0d: got %0h expected %0h", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_out_stall();
        logic [7:0] exp [4];
        exp = '{8'd5, 8'd6, 8'd7, 8'd8};
        out_ready = 1'b0;
        load4(8'd8, 8'd6, 8'd7, 8'd5);
        wait_sort();
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 3; s++) begin
                checks++; if (out_valid !== 1'b1 || out_data !== exp[k] || done !== 1'b0) begin failures++; $display("FAIL stall_word%0d_cyc%0d: got valid=%0b data=%0d done=%0b expected 1/%0d/0", k, s, out_valid, out_data, done, exp[k]); end
                tick();
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL stall_done: got done=%0b valid=%0b expected 1/0", done, out_valid); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_sort();
        logic [7:0] exp [4];
        exp = '{8'd6, 8'd7, 8'd8, 8'd9};
        load4(8'd2, 8'd9, 8'd1, 8'd4);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL midrst_ctrl: got in_ready=%0b busy=%0b out_valid=%0b expected 1/0/0", in_ready, busy, out_valid); end
        checks++; if (cmp_count !== 8'd0 || done !== 1'b0 || out_data !== 8'd0) begin failures++; $display("FAIL midrst_status: got cmp=%0d done=%0b data=%0d expected 0/0/0", cmp_count, done, out_data); end
        rst = 1'b0;
        tick();
        load4(8'd9, 8'd8, 8'd7, 8'd6);
        wait_sort();
        checks++; if (cmp_count !== 8'd6) begin failures++; $display("FAIL midrst_cmp_count: got %0d expected 6", cmp_count); end
        drain();
        for (int k = 0; k < 4; k++) begin
            checks++; if (got[k] !== exp[k]) begin failures++; $display("FAIL midrst_word%0d: got %0d expected %0d", k, got[k], exp[k]); end
        end
        checks++; if (got_done != 1) begin failures++; $display("FAIL midrst_done_pulses: got %0d expected 1", got_done); end
    endtask

    task automatic test_in_valid_held();
        logic [7:0] v [4];
        logic [7:0] exp1 [4];
        logic [7:0] exp2 [4];
        int cyc;
        int seen;
        int bad_ready;
        v    = '{8'd40, 8'd30, 8'd20, 8'd10};
        exp1 = '{8'd10, 8'd20, 8'd30, 8'd40};
        exp2 = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = v[k];
            tick();
        end
        cyc = 0;
        seen = 0;
        bad_ready = 0;
        while (!done && cyc < 100) begin
            if (in_ready) bad_ready++;
            if (out_valid) begin
                if (seen < 4) got[seen] = out_data;
                seen++;
            end
            in_data = 8'(8'hA0 + cyc);
            tick();
            cyc++;
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL held_done_timeout: got %0b expected 1", done); end
        checks++; if (bad_ready != 0) begin failures++; $display("FAIL held_in_ready_busy: got %0d cycles expected 0", bad_ready); end
        checks++; if (seen != 4) begin failures++; $display("FAIL held_word_count: got %0d expected 4", seen); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (got[k] !== exp1[k]) begin failures++; $display("FAIL held_word%0d: got %0d expected %0d", k, got[k], exp1[k]); end
        end
        load4(8'h33, 8'h11, 8'h44, 8'h22);
        wait_sort();
        checks++; if (sort_cycles != 6) begin failures++; $display("FAIL held_next_busy_cycles: got %0d expected 6", sort_cycles); end
        drain();
        for (int k = 0; k < 4; k++) begin
            checks++; if (got[k] !== exp2[k]) begin failures++; $display("FAIL held_next_word%0d: got %0h expected %0h", k, got[k], exp2[k]); end
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        checks    = 0;
        failures  = 0;
        test_reset();
        test_reverse();
        test_sorted();
        test_equal_words();
        test_out_stall();
        test_reset_mid_sort();
        test_in_valid_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
